uart_rx_os: RTL



---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_os.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit path.
// Contents:
//   DATA_BITS      - payload bits per frame (8N1)
//   rx_state_e     - receiver FSM states
//   calc_tick_div  - clocks per oversample tick; returns 0 when the rate is unreachable
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  // Integer division truncates; a result of 0 means the clock is too slow for the
  // requested baud/oversample combination and the caller must reject it.
  function automatic int unsigned calc_tick_div(input int unsigned clk_freq,
                                                input int unsigned baud,
                                                input int unsigned oversample);
    int unsigned denom;
    denom = baud * oversample;
    if (denom == 0) begin
      return 0;
    end
    return clk_freq / denom;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running tick generator: counts 0..DIV-1 and pulses tick_o for one clock when the
// counter reaches DIV-1. With DIV == 1 the tick is high on every clock.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset (counter to 0)
//   tick_o  - one-clock tick pulse
module uart_baud_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with an AXI-Stream master output.
// The line is synchronised, the start bit is re-checked at mid-bit, data bits are
// sampled LSB first every OVERSAMPLE ticks, and each good byte lands in a one-entry
// holding register behind tvalid/tready. Backpressure never stalls sampling.
// Ports:
//   clk_i            - system clock
//   rst_ni           - asynchronous active-low reset
//   uart_rx_i        - asynchronous serial input, idle high
//   m_axis_tdata_o   - received byte
//   m_axis_tvalid_o  - byte available
//   m_axis_tready_i  - downstream accepts byte
//   frame_err_o      - one-cycle pulse: stop bit sampled low
//   overrun_o        - one-cycle pulse: byte dropped, holding register full
//   busy_o           - FSM not idle
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 18432000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned ScW      = $clog2(OVERSAMPLE);
  localparam logic [ScW-1:0] ScMid  = ScW'(OVERSAMPLE / 2 - 1);
  localparam logic [ScW-1:0] ScLast = ScW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BcLast = 3'(DATA_BITS - 1);

  generate
    if (TICK_DIV < 1) begin : g_bad_div
      $error("uart_rx_os: CLK_FREQ too low for BAUD*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
      $error("uart_rx_os: OVERSAMPLE must be even and >= 4");
    end
  endgenerate

  logic tick;

  uart_baud_tick #(
    .DIV (TICK_DIV)
  ) u_baud_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick)
  );

  // Two-flop synchroniser; resets to the idle line level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  rx_state_e            state_q;
  logic [ScW-1:0]       sc_q;
  logic [2:0]           bc_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] tdata_q;
  logic                 tvalid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sc_q        <= '0;
      bc_q        <= '0;
      shreg_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A handshake empties the holding register unless a delivery below refills it.
      if (tvalid_q && m_axis_tready_i) begin
        tvalid_q <= 1'b0;
      end
      if (tick) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s_q) begin
              state_q <= StStart;
              sc_q    <= '0;
            end
          end
          StStart: begin
            if (sc_q == ScMid) begin
              if (!rx_s_q) begin
                state_q <= StData;
                sc_q    <= '0;
                bc_q    <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              sc_q <= sc_q + 1'b1;
            end
          end
          StData: begin
            if (sc_q == ScLast) begin
              shreg_q <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
              sc_q    <= '0;
              bc_q    <= bc_q + 1'b1;
              if (bc_q == BcLast) begin
                state_q <= StStop;
              end
            end else begin
              sc_q <= sc_q + 1'b1;
            end
          end
          StStop: begin
            if (sc_q == ScLast) begin
              sc_q <= '0;
              if (rx_s_q) begin
                state_q <= StIdle;
                if (!tvalid_q || m_axis_tready_i) begin
                  tdata_q  <= shreg_q;
                  tvalid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= StWaitHigh;
              end
            end else begin
              sc_q <= sc_q + 1'b1;
            end
          end
          StWaitHigh: begin
            // Break condition: hold here so a long low produces only one error pulse.
            if (rx_s_q) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign frame_err_o     = frame_err_q;
  assign overrun_o       = overrun_q;
  assign busy_o          = (state_q != StIdle);

endmodule
